io_timer_port: RTL

IO_TIMER_PORT -- requirements
Module: io_timer_port

---
 rtl/io_timer_port.sv | 112 +++++++++++
 1 files changed

// File: rtl/io_timer_port.sv
// rtl/io_timer_port.sv - CPU-mapped GPIO port with prescaled down-counting timer
module io_timer_port #(
  parameter logic [7:0] PORT_RESET = 8'h00,
  parameter logic [7:0] ADDR_BASE  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       i_bar,
  input  logic       we,
  input  logic [7:0] dataout,
  output logic [7:0] io_rdata,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       tmr_irq
);

  localparam logic [7:0] OFF_PORT_OUT = 8'd0;
  localparam logic [7:0] OFF_PORT_IN  = 8'd1;
  localparam logic [7:0] OFF_CTRL     = 8'd2;
  localparam logic [7:0] OFF_RELOAD   = 8'd3;
  localparam logic [7:0] OFF_COUNT    = 8'd4;
  localparam logic [7:0] OFF_STATUS   = 8'd5;
  localparam logic [7:0] OFF_PRESCALE = 8'd6;

  logic [7:0] offset;
  logic       wr_stb, rd_stb;
  logic       wr_port, wr_ctrl, wr_reload, wr_prescale, rd_status;
  logic [2:0] ctrl;
  logic [7:0] reload, count, prescale, pcnt;
  logic [1:0] status;
  logic [7:0] sync1, sync2, sync3;
  logic       tick, expire;

  assign offset      = address - ADDR_BASE;
  assign wr_stb      = i_bar & we;
  assign rd_stb      = i_bar & ~we;
  assign wr_port     = wr_stb && (offset == OFF_PORT_OUT);
  assign wr_ctrl     = wr_stb && (offset == OFF_CTRL);
  assign wr_reload   = wr_stb && (offset == OFF_RELOAD);
  assign wr_prescale = wr_stb && (offset == OFF_PRESCALE);
  assign rd_status   = rd_stb && (offset == OFF_STATUS);

  // A RELOAD write in the same cycle swallows the tick entirely.
  assign tick   = ctrl[0] && (pcnt == prescale) && !wr_reload;
  assign expire = tick && (count == 8'd0);

  assign tmr_irq = status[0] & ctrl[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      port_out <= PORT_RESET;
      ctrl     <= 3'd0;
      reload   <= 8'd0;
      count    <= 8'd0;
      status   <= 2'd0;
      prescale <= 8'd0;
      pcnt     <= 8'd0;
      sync1    <= 8'd0;
      sync2    <= 8'd0;
      sync3    <= 8'd0;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
      sync3 <= sync2;

      if (wr_port)     port_out <= dataout;
      if (wr_prescale) prescale <= dataout;

      if (wr_ctrl)
        ctrl <= dataout[2:0];
      else if (expire && !ctrl[1])
        ctrl[0] <= 1'b0;

      if (wr_reload || (wr_ctrl && dataout[0] && !ctrl[0]))
        pcnt <= 8'd0;
      else if (ctrl[0])
        pcnt <= (pcnt == prescale) ? 8'd0 : pcnt + 8'd1;

      if (wr_reload) begin
        reload <= dataout;
        count  <= dataout;
      end else if (tick) begin
        if (count != 8'd0)
          count <= count - 8'd1;
        else if (ctrl[1])
          count <= reload;
      end

      // Set wins over the clear-on-read.
      status[0] <= expire | (status[0] & ~rd_status);
      status[1] <= (sync2 != sync3) | (status[1] & ~rd_status);
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    if (rd_stb) begin
      case (offset)
        OFF_PORT_OUT: io_rdata = port_out;
        OFF_PORT_IN:  io_rdata = sync2;
        OFF_CTRL:     io_rdata = {5'd0, ctrl};
        OFF_RELOAD:   io_rdata = reload;
        OFF_COUNT:    io_rdata = count;
        OFF_STATUS:   io_rdata = {6'd0, status};
        OFF_PRESCALE: io_rdata = prescale;
        default:      io_rdata = 8'h00;
      endcase
    end
  end

endmodule
